// File: rtl/if_id_buffer.sv
// IF/ID pipeline register: captures fetch output each cycle, applies stall/flush,
// and injects the PUSH-PC / PUSH-FLAGS pseudo-op pair on interrupt entry.
module if_id_buffer #(
  parameter int unsigned            INST_W        = 32,
  parameter int unsigned            PC_W          = 32,
  parameter logic [INST_W-1:0]      NOP_OP        = 32'h0000_0000,
  parameter logic [INST_W-1:0]      PUSH_PC_OP    = 32'hF000_0000,
  parameter logic [INST_W-1:0]      PUSH_FLAGS_OP = 32'hF100_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] instruction_in,
  input  logic [PC_W-1:0]   pc_in,
  input  logic              int_flag_in,
  input  logic              stall_in,
  input  logic              flush_in,
  output logic [INST_W-1:0] instruction_out,
  output logic [PC_W-1:0]   pc_out,
  output logic              valid_out,
  output logic              int_seq_out,
  output logic              fetch_hold_out
);

  typedef enum logic [1:0] {IDLE, INT_PC, INT_FLAGS} state_t;

  state_t              state, state_n;
  logic [PC_W-1:0]     saved_pc, saved_pc_n;
  logic                int_pending, int_pending_n;
  logic [INST_W-1:0]   inst_n;
  logic [PC_W-1:0]     pc_n;
  logic                valid_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      saved_pc        <= '0;
      int_pending     <= 1'b0;
      instruction_out <= NOP_OP;
      pc_out          <= '0;
      valid_out       <= 1'b0;
    end else begin
      state           <= state_n;
      saved_pc        <= saved_pc_n;
      int_pending     <= int_pending_n;
      instruction_out <= inst_n;
      pc_out          <= pc_n;
      valid_out       <= valid_n;
    end
  end

  // Stall holds everything except that a request arriving during it is latched as pending.
  always_comb begin
    state_n       = state;
    saved_pc_n    = saved_pc;
    int_pending_n = int_pending;
    inst_n        = instruction_out;
    pc_n          = pc_out;
    valid_n       = valid_out;

    if (stall_in) begin
      if (int_flag_in) int_pending_n = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (flush_in) begin
            inst_n  = NOP_OP;
            pc_n    = pc_in;
            valid_n = 1'b0;
            if (int_flag_in) int_pending_n = 1'b1;
          end else if (int_flag_in || int_pending) begin
            saved_pc_n    = pc_in;
            inst_n        = PUSH_PC_OP;
            pc_n          = pc_in;
            valid_n       = 1'b1;
            int_pending_n = 1'b0;
            state_n       = INT_PC;
          end else begin
            inst_n  = instruction_in;
            pc_n    = pc_in;
            valid_n = 1'b1;
          end
        end
        INT_PC: begin
          inst_n  = PUSH_FLAGS_OP;
          pc_n    = saved_pc;
          valid_n = 1'b1;
          state_n = INT_FLAGS;
          if (int_flag_in) int_pending_n = 1'b1;
        end
        INT_FLAGS: begin
          inst_n  = instruction_in;
          pc_n    = pc_in;
          valid_n = 1'b1;
          state_n = IDLE;
          if (int_flag_in) int_pending_n = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign int_seq_out    = (state != IDLE);
  assign fetch_hold_out = (state != IDLE) | stall_in;

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed scenarios with literal
// expectations, then randomized traffic against a slot-counting reference model.
module tb_if_id_buffer;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] PUSHPC = 32'hF000_0000;
  localparam logic [31:0] PUSHFL = 32'hF100_0000;

  logic        clk = 1'b0;
  logic        rst, int_flag_in, stall_in, flush_in;
  logic [31:0] instruction_in, pc_in;
  logic [31:0] instruction_out, pc_out;
  logic        valid_out, int_seq_out, fetch_hold_out;

  int checks = 0;
  int errors = 0;

  if_id_buffer #(
    .INST_W(32), .PC_W(32),
    .NOP_OP(NOP), .PUSH_PC_OP(PUSHPC), .PUSH_FLAGS_OP(PUSHFL)
  ) dut (
    .clk(clk), .rst(rst),
    .instruction_in(instruction_in), .pc_in(pc_in),
    .int_flag_in(int_flag_in), .stall_in(stall_in), .flush_in(flush_in),
    .instruction_out(instruction_out), .pc_out(pc_out), .valid_out(valid_out),
    .int_seq_out(int_seq_out), .fetch_hold_out(fetch_hold_out)
  );

  always #5 clk = ~clk;

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: injected pseudo-ops are tracked as a count of slots left.
  logic [31:0] m_inst, m_pc, m_saved;
  logic        m_valid, m_pend;
  int          m_left;
  bit          started = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_inst = NOP; m_pc = '0; m_valid = 1'b0;
      m_left = 0; m_pend = 1'b0; m_saved = '0;
      started = 1;
    end else if (stall_in) begin
      if (int_flag_in) m_pend = 1'b1;
    end else if (m_left == 2) begin
      m_inst = PUSHFL; m_pc = m_saved; m_valid = 1'b1; m_left = 1;
      if (int_flag_in) m_pend = 1'b1;
    end else if (m_left == 1) begin
      m_inst = instruction_in; m_pc = pc_in; m_valid = 1'b1; m_left = 0;
      if (int_flag_in) m_pend = 1'b1;
    end else if (flush_in) begin
      m_inst = NOP; m_pc = pc_in; m_valid = 1'b0;
      if (int_flag_in) m_pend = 1'b1;
    end else if (int_flag_in || m_pend) begin
      m_saved = pc_in; m_inst = PUSHPC; m_pc = pc_in; m_valid = 1'b1;
      m_left = 2; m_pend = 1'b0;
    end else begin
      m_inst = instruction_in; m_pc = pc_in; m_valid = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      lit("model.instruction_out", instruction_out, m_inst);
      lit("model.pc_out", pc_out, m_pc);
      lit("model.valid_out", {31'b0, valid_out}, {31'b0, m_valid});
      lit("model.int_seq_out", {31'b0, int_seq_out}, {31'b0, m_left != 0});
      lit("model.fetch_hold_out", {31'b0, fetch_hold_out}, {31'b0, (m_left != 0) || stall_in});
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [31:0] inst, input logic [31:0] pc,
                       input logic intf, input logic st, input logic fl);
    rst = r; instruction_in = inst; pc_in = pc;
    int_flag_in = intf; stall_in = st; flush_in = fl;
  endtask

  initial begin
    drive(1, 32'h1234_5678, 32'h0, 0, 0, 0);
    tick; tick;
    lit("reset.inst", instruction_out, 32'h0);
    lit("reset.pc", pc_out, 32'h0);
    lit("reset.valid", {31'b0, valid_out}, 32'h0);
    lit("reset.hold", {31'b0, fetch_hold_out}, 32'h0);
    lit("reset.seq", {31'b0, int_seq_out}, 32'h0);

    drive(0, 32'hA1, 32'd1, 0, 0, 0); tick;
    lit("pass.pc1", pc_out, 32'd1);
    lit("pass.inst1", instruction_out, 32'hA1);
    drive(0, 32'hA2, 32'd2, 0, 0, 0); tick;
    lit("pass.pc2", pc_out, 32'd2);
    drive(0, 32'hA3, 32'd3, 0, 1, 0); #1;
    lit("stall.hold_hi", {31'b0, fetch_hold_out}, 32'h1);
    tick;
    lit("stall.pc_held", pc_out, 32'd2);
    lit("stall.inst_held", instruction_out, 32'hA2);
    drive(0, 32'hA3, 32'd3, 0, 0, 0); #1;
    lit("stall.hold_lo", {31'b0, fetch_hold_out}, 32'h0);
    tick;
    lit("pass.pc3", pc_out, 32'd3);

    drive(0, 32'hAAAA_0001, 32'd5, 0, 0, 1); tick;
    lit("flush.inst", instruction_out, 32'h0);
    lit("flush.valid", {31'b0, valid_out}, 32'h0);
    lit("flush.pc", pc_out, 32'd5);
    drive(0, 32'hA6, 32'd6, 0, 0, 0); tick;
    lit("flush.after", instruction_out, 32'hA6);
    lit("flush.after_valid", {31'b0, valid_out}, 32'h1);

    drive(0, 32'h0C0C_0C0C, 32'd27, 1, 0, 0); tick;
    lit("int.c1_inst", instruction_out, 32'hF000_0000);
    lit("int.c1_pc", pc_out, 32'd27);
    lit("int.c1_hold", {31'b0, fetch_hold_out}, 32'h1);
    lit("int.c1_seq", {31'b0, int_seq_out}, 32'h1);
    drive(0, 32'h0C0C_0C0C, 32'd27, 0, 0, 0); tick;
    lit("int.c2_inst", instruction_out, 32'hF100_0000);
    lit("int.c2_pc", pc_out, 32'd27);
    lit("int.c2_seq", {31'b0, int_seq_out}, 32'h1);
    tick;
    lit("int.c3_inst", instruction_out, 32'h0C0C_0C0C);
    lit("int.c3_seq", {31'b0, int_seq_out}, 32'h0);

    drive(0, 32'hBB, 32'd33, 1, 0, 1); tick;
    lit("flushint.bubble", instruction_out, 32'h0);
    lit("flushint.valid", {31'b0, valid_out}, 32'h0);
    drive(0, 32'hCC, 32'd34, 0, 0, 0); tick;
    lit("flushint.pushpc", instruction_out, 32'hF000_0000);
    lit("flushint.pc", pc_out, 32'd34);
    tick;
    lit("flushint.pushfl", instruction_out, 32'hF100_0000);
    tick;

    drive(0, 32'hDD, 32'd40, 1, 0, 0); tick;
    drive(0, 32'hDD, 32'd40, 0, 0, 0); tick;
    lit("rstseq.in_flags", instruction_out, 32'hF100_0000);
    drive(1, 32'hDD, 32'd40, 0, 0, 0); tick;
    lit("rstseq.inst", instruction_out, 32'h0);
    lit("rstseq.valid", {31'b0, valid_out}, 32'h0);
    lit("rstseq.hold", {31'b0, fetch_hold_out}, 32'h0);
    drive(0, 32'h41, 32'd41, 0, 0, 0); tick;
    lit("rstseq.after", instruction_out, 32'h41);
    drive(0, 32'h42, 32'd42, 0, 0, 0); tick;
    lit("rstseq.after2", instruction_out, 32'h42);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 59) == 0, $urandom, $urandom,
            $urandom_range(0, 11) == 0, $urandom_range(0, 6) == 0,
            $urandom_range(0, 6) == 0);
      tick;
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
